// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register family: stage state and control field layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 3;
    localparam int unsigned EX_W   = 3;
    localparam int unsigned EX_OFF = 0;
    localparam int unsigned M_OFF  = EX_OFF + EX_W;
    localparam int unsigned WB_OFF = M_OFF + M_W;

    localparam int unsigned CTRL_W_DEF   = WB_W + M_W + EX_W;
    localparam logic [CTRL_W_DEF-1:0] CTRL_RST_DEF = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid absorbs one extra entry
// so the upstream ready can be registered without losing throughput.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             acc, emt;

    assign acc = in_valid && ready_q;
    assign emt = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (acc && emt) begin
                    main_d = in_data;
                end else if (acc) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (emt) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (emt) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Clear discards everything, including an entry arriving this cycle.
        if (clr) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: skid-buffered register with stall, flush and control zeroing on bubbles.
// Optional performance counters enabled by defining ID_EX_PIPE_STAGE_PERF_EN.
module id_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      DATA_W   = 272,
    parameter int unsigned      CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEF)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] IData,
    input  logic [CTRL_W-1:0] ICtrl,
    input  logic              IValid,
    output logic              OReady,
    input  logic              IStall,
    input  logic              IFlush,
    output logic [DATA_W-1:0] OData,
    output logic [CTRL_W-1:0] OCtrl,
    output logic              OValid,
`ifdef ID_EX_PIPE_STAGE_PERF_EN
    output logic [31:0]       OStallCnt,
    output logic [31:0]       OBubbleCnt,
`endif
    input  logic              IReady
);

    localparam int unsigned PW = DATA_W + CTRL_W;

    logic [PW-1:0] out_payload;
    logic          buf_valid;
    logic          down_ready;

    // Stall looks like downstream backpressure to the buffer.
    assign down_ready = IReady && !IStall;

    pipe_skid_buf #(
        .WIDTH (PW)
    ) u_skid (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .clr       (IFlush),
        .in_valid  (IValid),
        .in_data   ({ICtrl, IData}),
        .in_ready  (OReady),
        .out_valid (buf_valid),
        .out_data  (out_payload),
        .out_ready (down_ready)
    );

    assign OValid = buf_valid;
    assign OData  = out_payload[DATA_W-1:0];
    assign OCtrl  = buf_valid ? out_payload[PW-1:DATA_W] : CTRL_RST;

`ifdef ID_EX_PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (buf_valid && (IStall || !IReady) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!buf_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign OStallCnt  = stall_cnt_q;
    assign OBubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised successor of the fixed-width ID/EX latch.
- A single-clock pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, stall, flush and bubble insertion.
- Sits between decode and execute. Also reusable at EX/MEM and MEM/WB by changing widths.
- Payload is split into data fields (held) and control fields (WB/M/EX bits), which are forced to zero on bubble or flush.

Parameters:
- DATA_W, 272, width of data payload (read data 1/2, PC, sign-extend, instruction fields).
- CTRL_W, 8, width of control payload (WB, M, EX bits); zeroed when the stage carries no valid instruction.
- CTRL_RST, 0, value driven on OCtrl when OValid=0.

Ports:
- Clk, input, 1, clock; all state updates on the rising edge.
- Rst_n, input, 1, synchronous active-low reset.
- IData, input, DATA_W, upstream data payload.
- ICtrl, input, CTRL_W, upstream control payload.
- IValid, input, 1, upstream holds a valid instruction.
- OReady, output, 1, stage can accept this cycle (registered).
- IStall, input, 1, hazard-unit stall; treated as downstream not ready.
- IFlush, input, 1, branch/exception flush; kills all held entries.
- OData, output, DATA_W, downstream data payload.
- OCtrl, output, CTRL_W, downstream control; equals CTRL_RST when OValid=0.
- OValid, output, 1, the output entry is valid.
- IReady, input, 1, downstream accepts this cycle.

Behaviour:
- Reset: applied on a rising Clk edge with Rst_n=0.
  - State becomes EMPTY.
  - OValid=0, OReady=1, OCtrl=CTRL_RST, OData=0.
  - Skid contents cleared.
- Handshakes:
  - Accept occurs when IValid && OReady.
  - Emit occurs when OValid && IReady && !IStall.
- Latency: an accepted entry appears on OData/OCtrl in the next cycle when the stage was EMPTY or emitting (1-cycle latency, full throughput).
- States: EMPTY (no entries), ONE (main register full), TWO (main and skid full).
  - EMPTY: on accept -> ONE, main loaded.
  - ONE:
    - accept and emit -> ONE, main reloaded.
    - accept without emit -> TWO, skid loaded.
    - emit without accept -> EMPTY.
    - otherwise hold.
  - TWO: OReady=0.
    - on emit -> ONE, main loaded from skid.
    - otherwise hold.
  - Accept is impossible in TWO.
- OReady is a registered value, 1 in EMPTY/ONE and 0 in TWO. No combinational path exists from IReady or IStall to OReady.
- Data ordering is strictly FIFO; no entry is ever dropped or duplicated.
- Flush:
  - IFlush=1 at an edge forces EMPTY regardless of IValid, IReady or IStall. Any accept in that cycle is discarded.
  - Next cycle: OValid=0, OCtrl=CTRL_RST, OReady=1.
- Priority: Rst_n > IFlush > normal operation.
- IStall=1 with OValid=1: outputs held stable and nothing emitted. Upstream may still fill the skid (ONE->TWO).
- Bubble: whenever OValid=0, OCtrl=CTRL_RST. OData holds its last value (don't-care).
- Stable output: while OValid=1 and no emit occurs, OData/OCtrl do not change.
- Upstream contract: IValid high with OReady low is legal; the entry must remain presented until accepted.

Optional Feature:
- Macro: ID_EX_PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs OStallCnt[31:0] (cycles with OValid && (IStall || !IReady)) and OBubbleCnt[31:0] (cycles with OValid=0, excluding reset).
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset. Flush does not clear them.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef for the stage state enum {EMPTY, ONE, TWO};
  - localparams for WB/M/EX field widths (2/3/3) and their CTRL offsets;
  - the default CTRL_RST.
- One natural sub-module, pipe_skid_buf: a generic 2-entry skid holding {ctrl, data}. The top adds stall, flush and control zeroing.

Test Plan:
- Reset: hold Rst_n=0 for 2 edges with IValid=1 -> OValid=0, OReady=1, OCtrl=0 after each edge; no accept.
- Streaming: IValid=1 and IReady=1 with IData=1,2,3,4 on consecutive cycles -> OData=1,2,3,4 one cycle later, OValid continuous, OReady stays 1.
- Backpressure:
  - IReady=0 while A, then B, is sent -> state TWO, OReady=0, OData=A held.
  - Then IReady=1 -> A emitted, then B; OReady returns to 1 one cycle after the first emit.
- Stall: IStall=1 for 3 cycles with OValid=1, IReady=1 -> OData/OCtrl stable, no emit; the released sequence order is preserved.
- Flush: stage in TWO, IFlush=1 with IValid=1 and ICtrl=8'hFF -> next cycle OValid=0, OCtrl=0, OReady=1; the flushed entries never appear.
- Perf (macro on): IReady=0 for 5 cycles with OValid=1 -> OStallCnt=5. Preload OBubbleCnt near max (force) -> saturates at FFFF_FFFF.
